inst_issue_ctrl: RTL and testbench
==================================

Name: inst_issue_ctrl

Overview:
- Sequencer that feeds the instruction-classification/counting datapath one 32-bit MIPS instruction per handshake.
- Holds an 8-entry instruction buffer loaded through a write port.
- On start, issues entries 0..len-1 in order, with a valid/ready handshake to the downstream counter block.
- Each issued instruction is tagged with a pre-decoded kind and destination register, so the consumer needs no decode logic.

Parameters:
- AW, 3, buffer address width; depth = 2**AW = 8 entries.
- LW, 4, width of len and issued_cnt; must be able to hold the value 2**AW.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high reset, sampled on posedge clk.
- ld_en, input, 1, buffer write strobe.
- ld_addr, input, AW, buffer write address.
- ld_data, input, 32, buffer write data.
- start, input, 1, begin issuing a program (level sampled per cycle).
- len, input, LW, program length, sampled on accepted start.
- out_ready, input, 1, downstream accepts the current instruction.
- out_valid, output, 1, out_inst/out_pc/out_kind/out_dst are valid.
- out_inst, output, 32, instruction word at out_pc.
- out_pc, output, AW, buffer index of the issued instruction.
- out_kind, output, 2, 0 = R (opcode 0x00), 2 = J (opcode 0x02 or 0x03), 1 = I (all other opcodes); 3 is never driven.
- out_dst, output, 5, destination register: inst[15:11] for R, inst[20:16] for I, 0 for J.
- busy, output, 1, high while in ISSUE.
- done, output, 1, one-cycle pulse at program completion.
- issued_cnt, output, LW, number of handshakes completed in the current or last program.

Behaviour:

Reset values:
- state = IDLE; pc = 0; latched length = 0; issued_cnt = 0.
- out_valid = 0, busy = 0, done = 0.
- Buffer contents are NOT cleared by reset.

State IDLE:
- out_valid = 0.
- start = 1 with len != 0: latch min(len, 8), set pc = 0, clear issued_cnt, go to ISSUE.
- start = 1 with len == 0: clear issued_cnt, go to DONE.

State ISSUE:
- busy = 1, out_valid = 1.
- out_inst = buf[pc], read combinationally from the registered pc.
- out_pc = pc; out_kind and out_dst are decoded combinationally from out_inst.
- Transfer occurs when out_valid && out_ready at posedge: issued_cnt += 1.
- On transfer with pc == latched length - 1: go to DONE. Otherwise pc += 1.
- While out_ready = 0, all out_* stay stable; no skipping, no repeats.
- Back-to-back transfers: one instruction per cycle when out_ready is held high.

State DONE:
- Lasts exactly one cycle: done = 1, out_valid = 0, busy = 0; then go to IDLE.
- start during DONE is ignored.

Latency:
- First out_valid appears in the cycle after start is sampled.
- len = N with out_ready held high gives N valid cycles, then a 1-cycle done pulse.
- Total time from start to done is N + 1 cycles.

Buffer writes:
- ld_en writes buf[ld_addr] = ld_data at posedge, only in IDLE or DONE.
- ld_en during ISSUE is ignored, so the running program is immutable.
- ld_en and start in the same IDLE cycle: the write commits first, so an issue from that address returns the new data.

Boundaries:
- len > 8 is clamped to 8.
- pc never wraps, because the last index is reached only via the DONE transition.
- issued_cnt holds its final value until the next accepted start or reset.
- start in ISSUE is ignored.
- reset asserted mid-ISSUE: next cycle is IDLE with out_valid = 0. No done pulse is produced, and pending instructions are dropped.

Test Plan:
1. Reset, then load buf[0..2] = 0x00A41820 (R, rd = 3), 0x20050004 (addi, rt = 5), 0x08000000 (J). Start with len = 3 and out_ready = 1. Required: out_valid for 3 consecutive cycles with out_kind/out_dst = 0/3, 1/5, 2/0 and out_pc = 0, 1, 2. Then done = 1 for one cycle, and issued_cnt = 3.
2. Same program, with out_ready low for 2 cycles during pc = 1. Required: out_inst stays 0x20050004 and out_pc stays 1 through the stall. Total valid cycles = 5, and done fires exactly once.
3. Start with len = 0. Required: done = 1 in the next cycle, out_valid never rises, issued_cnt = 0. Start with len = 12. Required: exactly 8 transfers, pc 0..7, issued_cnt = 8.
4. Assert ld_en to addr 1 with 0xFFFFFFFF during ISSUE. Required: issued word at pc = 1 is unchanged. After done, a rerun issues 0xFFFFFFFF at pc = 1, with out_kind = 1 and out_dst = 31.
5. Assert reset at pc = 2 of an 8-long program. Required: next cycle out_valid = 0, busy = 0, done = 0, issued_cnt = 0. A restart replays from pc = 0 with buffer contents intact.
6. Assert ld_en to addr 0 with 0x00C63020 and start with len = 1 in the same IDLE cycle. Required: issued out_inst = 0x00C63020, out_kind = 0, out_dst = 6.

Source files
------------

// File: rtl/inst_issue_ctrl.sv
// Instruction issue sequencer: 8-entry program buffer issued in order
// over a valid/ready handshake, each word tagged with kind and dest reg.
module inst_issue_ctrl #(
    parameter int AW = 3,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [31:0]   out_inst,
    output logic [AW-1:0] out_pc,
    output logic [1:0]    out_kind,
    output logic [4:0]    out_dst,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] issued_cnt
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] K_R = 2'd0;
    localparam logic [1:0] K_I = 2'd1;
    localparam logic [1:0] K_J = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem_q [DEPTH];
    logic [5:0]    opcode;
    logic          last;

    // Program buffer: writable only while no program is running
    always_ff @(posedge clk) begin
        if (ld_en && state_q != S_ISSUE) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    assign last = (LW'(pc_q) == len_q - LW'(1));

    // Sequencer next-state: accept start, step pc on each transfer
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (len != '0) begin
                        len_d   = (len > DEPTH_L) ? DEPTH_L : len;
                        pc_d    = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (out_ready) begin
                    cnt_d = cnt_q + LW'(1);
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = (state_q == S_ISSUE);
    assign busy       = (state_q == S_ISSUE);
    assign done       = (state_q == S_DONE);
    assign issued_cnt = cnt_q;
    assign out_pc     = pc_q;
    assign out_inst   = mem_q[pc_q];
    assign opcode     = out_inst[31:26];

    // Pre-decode so the consumer sees kind and destination directly
    always_comb begin
        out_kind = K_I;
        out_dst  = out_inst[20:16];
        if (opcode == 6'h00) begin
            out_kind = K_R;
            out_dst  = out_inst[15:11];
        end else if (opcode == 6'h02 || opcode == 6'h03) begin
            out_kind = K_J;
            out_dst  = 5'd0;
        end
    end

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Randomized bench for inst_issue_ctrl against a transaction-level
// model of the program buffer and in-order issue stream.
module tb_inst_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic        start;
    logic [3:0]  len;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [2:0]  out_pc;
    logic [1:0]  out_kind;
    logic [4:0]  out_dst;
    logic        busy;
    logic        done;
    logic [3:0]  issued_cnt;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_mem [8];

    inst_issue_ctrl #(.AW(3), .LW(4)) dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .len(len), .out_ready(out_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_kind(out_kind), .out_dst(out_dst),
        .busy(busy), .done(done), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_kind(input logic [31:0] w);
        int op;
        op = int'(w >> 26);
        if (op == 0) return 2'd0;
        if (op == 2 || op == 3) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [4:0] ref_dst(input logic [31:0] w);
        int op;
        op = int'(w >> 26);
        if (op == 0) return 5'((w >> 11) & 32'h1f);
        if (op == 2 || op == 3) return 5'd0;
        return 5'((w >> 16) & 32'h1f);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 3'(a); ld_data = d;
        tick;
        ld_en = 1'b0;
        model_mem[a] = d;
    endtask

    // mode 0: always ready, 1: random ready, 2: 2-cycle stall at pc 1
    task automatic run_prog(input int n, input int mode, input bit inject);
        int eff, idx, cyc, vcnt, stall;
        bit rdy;
        eff = (n > 8) ? 8 : n;
        start = 1'b1; len = 4'(n);
        tick;
        start = 1'b0;
        if (eff == 0) begin
            tests++;
            if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL len0_done: done=%b valid=%b busy=%b want 1 0 0",
                         done, out_valid, busy);
            else ;
            if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) fails++;
            tests++;
            if (issued_cnt !== 4'd0) begin
                fails++;
                $display("FAIL len0_cnt: got %0d want 0", issued_cnt);
            end
            tick;
            tests++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL len0_after: done=%b valid=%b want 0 0", done, out_valid);
            end
            return;
        end
        idx = 0; cyc = 0; vcnt = 0; stall = 0;
        while (idx < eff && cyc < 100) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = !(idx == 1 && stall < 2);
                    if (!rdy) stall++;
                end
            endcase
            out_ready = rdy;
            tests++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL issue_ctrl idx=%0d: valid=%b busy=%b done=%b want 1 1 0",
                         idx, out_valid, busy, done);
            end
            tests++;
            if (out_pc !== 3'(idx) || out_inst !== model_mem[idx]) begin
                fails++;
                $display("FAIL issue_data: pc=%0d inst=%h want pc=%0d inst=%h",
                         out_pc, out_inst, idx, model_mem[idx]);
            end
            tests++;
            if (out_kind !== ref_kind(model_mem[idx]) ||
                out_dst !== ref_dst(model_mem[idx])) begin
                fails++;
                $display("FAIL issue_decode idx=%0d: kind=%0d dst=%0d want %0d %0d",
                         idx, out_kind, out_dst,
                         ref_kind(model_mem[idx]), ref_dst(model_mem[idx]));
            end
            if (inject && cyc == 0) begin
                ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'hFFFF_FFFF;
            end else begin
                ld_en = 1'b0;
            end
            vcnt++;
            tick;
            if (rdy) idx++;
            cyc++;
        end
        ld_en = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (cyc >= 100) begin
            fails++;
            $display("FAIL issue_timeout: idx=%0d want %0d", idx, eff);
        end
        tests++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            issued_cnt !== 4'(eff)) begin
            fails++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b cnt=%0d want 1 0 0 %0d",
                     done, out_valid, busy, issued_cnt, eff);
        end
        if (mode == 2) begin
            tests++;
            if (vcnt != eff + 2) begin
                fails++;
                $display("FAIL stall_cycles: got %0d want %0d", vcnt, eff + 2);
            end
        end
        tick;
        tests++;
        if (done !== 1'b0 || out_valid !== 1'b0 || issued_cnt !== 4'(eff)) begin
            fails++;
            $display("FAIL post_done: done=%b valid=%b cnt=%0d want 0 0 %0d",
                     done, out_valid, issued_cnt, eff);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            issued_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                     out_valid, busy, done, issued_cnt);
        end
    endtask

    task automatic load_basic;
        load(0, 32'h00A4_1820);
        load(1, 32'h2005_0004);
        load(2, 32'h0800_0000);
    endtask

    task automatic test_basic;
        load_basic;
        start = 1'b1; len = 4'd3; out_ready = 1'b1;
        tick;
        start = 1'b0;
        tests++;
        if (out_kind !== 2'd0 || out_dst !== 5'd3 || out_pc !== 3'd0) begin
            fails++;
            $display("FAIL basic_pc0: kind=%0d dst=%0d pc=%0d want 0 3 0",
                     out_kind, out_dst, out_pc);
        end
        tick;
        tests++;
        if (out_kind !== 2'd1 || out_dst !== 5'd5 || out_pc !== 3'd1) begin
            fails++;
            $display("FAIL basic_pc1: kind=%0d dst=%0d pc=%0d want 1 5 1",
                     out_kind, out_dst, out_pc);
        end
        tick;
        tests++;
        if (out_kind !== 2'd2 || out_dst !== 5'd0 || out_pc !== 3'd2) begin
            fails++;
            $display("FAIL basic_pc2: kind=%0d dst=%0d pc=%0d want 2 0 2",
                     out_kind, out_dst, out_pc);
        end
        tick;
        out_ready = 1'b0;
        tests++;
        if (done !== 1'b1 || issued_cnt !== 4'd3) begin
            fails++;
            $display("FAIL basic_done: done=%b cnt=%0d want 1 3", done, issued_cnt);
        end
        tick;
        run_prog(3, 0, 1'b0);
    endtask

    task automatic test_stall;
        run_prog(3, 2, 1'b0);
    endtask

    task automatic test_len_bounds;
        run_prog(0, 0, 1'b0);
        for (int i = 0; i < 8; i++) load(i, $urandom);
        run_prog(12, 0, 1'b0);
    endtask

    task automatic test_ld_during_issue;
        load_basic;
        run_prog(3, 0, 1'b1);
        load(1, 32'hFFFF_FFFF);
        start = 1'b1; len = 4'd3; out_ready = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tests++;
        if (out_pc !== 3'd1 || out_inst !== 32'hFFFF_FFFF ||
            out_kind !== 2'd1 || out_dst !== 5'd31) begin
            fails++;
            $display("FAIL reload_pc1: pc=%0d inst=%h kind=%0d dst=%0d want 1 ffffffff 1 31",
                     out_pc, out_inst, out_kind, out_dst);
        end
        tick; tick;
        out_ready = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8; i++) load(i, $urandom);
        start = 1'b1; len = 4'd8; out_ready = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        tests++;
        if (out_pc !== 3'd2 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_pc: pc=%0d valid=%b want 2 1", out_pc, out_valid);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            issued_cnt !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                     out_valid, busy, done, issued_cnt);
        end
        tick;
        tests++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_nodone: done=%b valid=%b want 0 0", done, out_valid);
        end
        run_prog(8, 1, 1'b0);
    endtask

    task automatic test_ld_and_start;
        ld_en = 1'b1; ld_addr = 3'd0; ld_data = 32'h00C6_3020;
        start = 1'b1; len = 4'd1;
        tick;
        ld_en = 1'b0; start = 1'b0;
        model_mem[0] = 32'h00C6_3020;
        tests++;
        if (out_valid !== 1'b1 || out_inst !== 32'h00C6_3020 ||
            out_kind !== 2'd0 || out_dst !== 5'd6) begin
            fails++;
            $display("FAIL ld_start: valid=%b inst=%h kind=%0d dst=%0d want 1 00c63020 0 6",
                     out_valid, out_inst, out_kind, out_dst);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tests++;
        if (done !== 1'b1 || issued_cnt !== 4'd1) begin
            fails++;
            $display("FAIL ld_start_done: done=%b cnt=%0d want 1 1", done, issued_cnt);
        end
        tick;
    endtask

    task automatic test_random;
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 3; k++) load($urandom_range(0, 7), $urandom);
            run_prog($urandom_range(0, 15), 1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; len = '0; out_ready = 1'b0;
        test_reset;
        test_basic;
        test_stall;
        test_len_bounds;
        test_ld_during_issue;
        test_reset_mid;
        test_ld_and_start;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
